// File: rtl/reg_bank8_if.sv
// Write/read bus for reg_bank8: one write port, one registered read port, written flags.
interface reg_bank8_if #(
    parameter int unsigned BUS_WIDTH = 16
);
    logic                 wr_en;
    logic [2:0]           wr_addr;
    logic [BUS_WIDTH-1:0] wr_data;
    logic                 rd_en;
    logic [2:0]           rd_addr;
    logic [BUS_WIDTH-1:0] rd_data;
    logic                 rd_valid;
    logic [7:0]           written;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, written
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, written
    );
endinterface

// File: rtl/reg_bank8.sv
// Eight-entry register bank with demultiplexed write strobe and 1-cycle registered read.
// Optional REG_BANK_BYPASS_EN forwards same-address write data to a same-cycle read.
module reg_bank8 #(
    parameter int unsigned BUS_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    reg_bank8_if.slave  bus
);
    localparam int unsigned N_ENTRIES = 8;

    logic [BUS_WIDTH-1:0] r_mem [N_ENTRIES];
    logic [BUS_WIDTH-1:0] r_rd_data;
    logic                 r_rd_valid;
    logic [N_ENTRIES-1:0] r_written;

    logic [N_ENTRIES-1:0] w_wr_sel;
    logic [BUS_WIDTH-1:0] w_rd_word;

    // 1-to-8 demux of the write strobe
    always_comb begin
        w_wr_sel = '0;
        if (bus.wr_en) begin
            w_wr_sel[bus.wr_addr] = 1'b1;
        end
    end

    // Read word selection; the bypass build forwards a colliding write
    always_comb begin
        w_rd_word = r_mem[bus.rd_addr];
`ifdef REG_BANK_BYPASS_EN
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
            w_rd_word = bus.wr_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_written  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_ENTRIES; i++) begin
                if (w_wr_sel[i]) begin
                    r_mem[i] <= bus.wr_data;
                end
            end
            r_written  <= r_written | w_wr_sel;
            r_rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
    assign bus.written  = r_written;
endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: directed vectors, literal checks, and a per-cycle model compare.
module tb_reg_bank8;
    localparam int unsigned BW = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reg_bank8_if #(.BUS_WIDTH(BW)) bus ();

    reg_bank8 #(.BUS_WIDTH(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    // Behavioural model: array of words, flag vector, expected read result
    logic [BW-1:0] m_mem [8];
    logic [7:0]    m_written;
    logic [BW-1:0] m_rd_data;
    logic          m_rd_valid;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_mem[i] = '0;
            m_written  = 8'h00;
            m_rd_data  = '0;
            m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = bus.rd_en;
            if (bus.rd_en) begin
                m_rd_data = m_mem[bus.rd_addr];
`ifdef REG_BANK_BYPASS_EN
                if (bus.wr_en && bus.wr_addr == bus.rd_addr) m_rd_data = bus.wr_data;
`endif
            end
            if (bus.wr_en) begin
                m_mem[bus.wr_addr]    = bus.wr_data;
                m_written[bus.wr_addr] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle once reset has been applied
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
            check("model_rd_data",  32'(bus.rd_data),  32'(m_rd_data));
            check("model_written",  32'(bus.written),  32'(m_written));
        end
    end

    task automatic step(input logic rst_v, input logic we, input logic [2:0] wa,
                        input logic [BW-1:0] wd, input logic re, input logic [2:0] ra);
        rst_n       = rst_v;
        bus.wr_en   = we;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_en   = re;
        bus.rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [BW-1:0] d);
        step(1'b1, 1'b1, a, d, 1'b0, 3'd0);
    endtask

    task automatic rd(input logic [2:0] a);
        step(1'b1, 1'b0, 3'd0, '0, 1'b1, a);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 3'd0, '0, 1'b0, 3'd0);
    endtask

    initial begin
        #2;
        // Reset held two cycles while a write is attempted
        step(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b0, 3'd0);
        chk_en = 1'b1;
        step(1'b0, 1'b1, 3'd3, 16'hFFFF, 1'b0, 3'd0);
        check("rst_rd_data",  32'(bus.rd_data),  32'h0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        check("rst_written",  32'(bus.written),  32'h00);
        rd(3'd3);
        check("rst_read3_data",  32'(bus.rd_data),  32'h0000);
        check("rst_read3_valid", 32'(bus.rd_valid), 32'h1);

        // Isolation around entry 5
        wr(3'd4, 16'h4444);
        wr(3'd6, 16'h6666);
        check("iso_written_pre", 32'(bus.written), 32'h50);
        wr(3'd5, 16'hBEEF);
        check("iso_written_post", 32'(bus.written), 32'h70);
        rd(3'd4);
        check("iso_read4", 32'(bus.rd_data), 32'h4444);
        rd(3'd6);
        check("iso_read6", 32'(bus.rd_data), 32'h6666);
        rd(3'd5);
        check("iso_read5", 32'(bus.rd_data), 32'hBEEF);

        // Fill all entries, then read back-to-back with rd_en held
        for (int i = 0; i < 8; i++) wr(3'(i), 16'h1000 + 16'(i));
        check("fill_written", 32'(bus.written), 32'hFF);
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            check("b2b_valid", 32'(bus.rd_valid), 32'h1);
            check("b2b_data",  32'(bus.rd_data),  32'h1000 + 32'(i));
        end

        // Same-cycle read and write to different addresses
        step(1'b1, 1'b1, 3'd1, 16'h5555, 1'b1, 3'd0);
        check("diff_addr_read0", 32'(bus.rd_data), 32'h1000);
        rd(3'd1);
        check("diff_addr_read1", 32'(bus.rd_data), 32'h5555);

        // Same-address collision
        wr(3'd2, 16'h1111);
        step(1'b1, 1'b1, 3'd2, 16'h2222, 1'b1, 3'd2);
`ifdef REG_BANK_BYPASS_EN
        check("collide_data", 32'(bus.rd_data), 32'h2222);
`else
        check("collide_data", 32'(bus.rd_data), 32'h1111);
`endif
        rd(3'd2);
        check("collide_next", 32'(bus.rd_data), 32'h2222);

        // Idle hold after a read of ABCD
        wr(3'd7, 16'hABCD);
        rd(3'd7);
        check("hold_first", 32'(bus.rd_data), 32'hABCD);
        for (int i = 0; i < 3; i++) begin
            idle();
            check("hold_valid", 32'(bus.rd_valid), 32'h0);
            check("hold_data",  32'(bus.rd_data),  32'hABCD);
        end

        // Reset with a read request in the same cycle
        step(1'b0, 1'b0, 3'd0, '0, 1'b1, 3'd7);
        check("midrst_valid",   32'(bus.rd_valid), 32'h0);
        check("midrst_written", 32'(bus.written),  32'h00);
        check("midrst_data",    32'(bus.rd_data),  32'h0);
        rd(3'd7);
        check("midrst_read7", 32'(bus.rd_data),  32'h0000);
        check("midrst_valid1", 32'(bus.rd_valid), 32'h1);
        idle();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
